// File: rtl/event_enc4to2_pkg.sv
// Shared definitions for the four-line event encoder: sizes, FSM state
// encoding, round-robin pointer reset value and a one-hot helper.
package enc_pkg;

  // Number of event lines and width of the binary code that names one line.
  localparam int N     = 4;
  localparam int IDX_W = 2;

  // Pointer reset value: "line 3 was consumed last", so line 0 wins first.
  localparam logic [IDX_W-1:0] RR_RESET = 2'd3;

  // Output handshake FSM: nothing presented, or a code held on out.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // Expand a binary line number into its one-hot line mask.
  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] mask;
    mask = 4'b0001 << idx;
    return mask;
  endfunction

endpackage

// File: rtl/event_enc4to2_rr_pick4.sv
// Round-robin picker over four request bits. Purely combinational: returns
// the first set bit of mask searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_pick4
  import enc_pkg::*;
(
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Walk the four candidates in priority order and keep the first hit.
  always_comb begin
    found_s = 1'b0;
    idx     = 2'd0;
    cand_s  = 2'd0;
    for (int k = 1; k <= N; k++) begin
      cand_s = ptr + 2'(k);
      if (!found_s && mask[cand_s]) begin
        found_s = 1'b1;
        idx     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    any = found_s;
  end

endmodule

// File: rtl/event_enc4to2.sv
// Four-line event encoder. Event strobes are latched into pending bits and
// drained one binary code per valid/ready handshake in round-robin order.
// All outputs come straight from registers.
module event_enc4to2
  import enc_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     in,
  output logic [IDX_W-1:0] out,
  output logic             valid,
  input  logic             ready,
  output logic [N-1:0]     pending,
  output logic             overflow
);

  state_t           state_r;
  state_t           state_next_s;
  logic [IDX_W-1:0] out_r;
  logic [IDX_W-1:0] out_next_s;
  logic [IDX_W-1:0] last_r;
  logic [IDX_W-1:0] last_next_s;
  logic             valid_r;
  logic             valid_next_s;
  logic [N-1:0]     pending_r;
  logic [N-1:0]     pending_next_s;
  logic             overflow_r;
  logic             overflow_next_s;

  logic             handshake_s;
  logic [N-1:0]     clr_s;
  logic [N-1:0]     mask_s;
  logic [IDX_W-1:0] ptr_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;

  assign out      = out_r;
  assign valid    = valid_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

  // Consumption of the presented code and the resulting pending update.
  // A new event on a line being cleared this cycle re-pends it (set wins);
  // an event on a line that stays pending is reported as overflow.
  always_comb begin
    handshake_s = valid_r & ready;
    if (handshake_s) begin
      clr_s = onehot(out_r);
    end else begin
      clr_s = 4'b0000;
    end
    pending_next_s  = (pending_r & ~clr_s) | in;
    overflow_next_s = |(in & pending_r & ~clr_s);
  end

  // Picker inputs: from IDLE search all pending lines after the last consumed
  // one; in HOLD look past the code being handed off right now.
  always_comb begin
    case (state_r)
      S_HOLD: begin
        mask_s = pending_r & ~onehot(out_r);
        ptr_s  = out_r;
      end
      S_IDLE: begin
        mask_s = pending_r;
        ptr_s  = last_r;
      end
      default: begin
        mask_s = pending_r;
        ptr_s  = last_r;
      end
    endcase
  end

  rr_pick4 u_pick (
    .mask (mask_s),
    .ptr  (ptr_s),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // Next-state logic: load a code when work appears, hold it while stalled,
  // and chain straight to the next eligible line on each handshake.
  always_comb begin
    state_next_s = state_r;
    out_next_s   = out_r;
    valid_next_s = valid_r;
    last_next_s  = last_r;
    case (state_r)
      S_IDLE: begin
        if (pick_any_s) begin
          out_next_s   = pick_idx_s;
          valid_next_s = 1'b1;
          state_next_s = S_HOLD;
        end else begin
          valid_next_s = 1'b0;
          state_next_s = S_IDLE;
        end
      end
      S_HOLD: begin
        if (handshake_s) begin
          last_next_s = out_r;
          if (pick_any_s) begin
            out_next_s   = pick_idx_s;
            valid_next_s = 1'b1;
            state_next_s = S_HOLD;
          end else begin
            valid_next_s = 1'b0;
            state_next_s = S_IDLE;
          end
        end else begin
          valid_next_s = 1'b1;
          state_next_s = S_HOLD;
        end
      end
      default: begin
        out_next_s   = 2'd0;
        valid_next_s = 1'b0;
        last_next_s  = RR_RESET;
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State, output and pending registers with synchronous reset; reset drops
  // any presented code and all pending events without a handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_IDLE;
      out_r      <= 2'd0;
      valid_r    <= 1'b0;
      last_r     <= RR_RESET;
      pending_r  <= 4'b0000;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      out_r      <= out_next_s;
      valid_r    <= valid_next_s;
      last_r     <= last_next_s;
      pending_r  <= pending_next_s;
      overflow_r <= overflow_next_s;
    end
  end

endmodule

// File: tb/tb_event_enc4to2.sv
// Directed bench for event_enc4to2. Stimulus pushes the hand-computed code
// sequence into a queue; a monitor process pops one entry per handshake.
module tb_event_enc4to2;

  logic       clock;
  logic       reset;
  logic [3:0] in;
  logic [1:0] out;
  logic       valid;
  logic       ready;
  logic [3:0] pending;
  logic       overflow;

  int         vectors;
  int         miscompares;
  logic [1:0] exp_q[$];

  event_enc4to2 dut (
    .clock    (clock),
    .reset    (reset),
    .in       (in),
    .out      (out),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in    = 4'b0000;
    ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in          = 4'b0000;
    ready       = 1'b0;

    // Monitor: a handshake happens at the next rising edge whenever valid and
    // ready are both high mid-cycle; each one must match the queue head.
    fork
      begin
        logic [1:0] e;
        forever begin
          @(negedge clock);
          if (!reset && valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
              check("unexpected_code", {30'd0, out}, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("code", {30'd0, out}, {30'd0, e});
            end
          end
        end
      end
    join_none

    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_out", {30'd0, out}, 32'd0);
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // Single event on line 2.
    do_reset();
    ready = 1'b1;
    in    = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    in = 4'b0000;
    check("single_pend", {28'd0, pending}, 32'h4);
    check("single_nvalid", {31'd0, valid}, 32'd0);
    tick();
    check("single_valid", {31'd0, valid}, 32'd1);
    tick();
    check("single_clr", {28'd0, pending}, 32'd0);
    check("single_idle", {31'd0, valid}, 32'd0);
    tick();
    check("single_drain", exp_q.size(), 32'd0);

    // All four lines at once: 0,1,2,3 back to back, never overflow.
    do_reset();
    ready = 1'b1;
    in    = 4'b1111;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    tick();
    in = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      check("all_noovf", {31'd0, overflow}, 32'd0);
      tick();
    end
    check("all_idle", {31'd0, valid}, 32'd0);
    check("all_pend", {28'd0, pending}, 32'd0);
    check("all_drain", exp_q.size(), 32'd0);

    // Stall: code 0 held stable while ready is low, then 0 and 1 drain.
    do_reset();
    ready = 1'b0;
    in    = 4'b0011;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    tick();
    in = 4'b0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, valid}, 32'd1);
      check("stall_out", {30'd0, out}, 32'd0);
      tick();
    end
    ready = 1'b1;
    tick();
    tick();
    check("stall_idle", {31'd0, valid}, 32'd0);
    check("stall_drain", exp_q.size(), 32'd0);

    // Fairness: consume line 1 first, then pending 1011 drains as 3,0,1.
    do_reset();
    ready = 1'b1;
    in    = 4'b0010;
    exp_q.push_back(2'd1);
    tick();
    in = 4'b0000;
    tick();
    tick();
    check("fair_idle0", {31'd0, valid}, 32'd0);
    in = 4'b1011;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    tick();
    in = 4'b0000;
    check("fair_pend", {28'd0, pending}, 32'hB);
    for (int i = 0; i < 4; i++) tick();
    check("fair_idle", {31'd0, valid}, 32'd0);
    check("fair_drain", exp_q.size(), 32'd0);

    // Overflow while line 2 is stalled, then set-wins on the handshake.
    do_reset();
    ready = 1'b0;
    in    = 4'b0100;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd2);
    tick();
    in = 4'b0000;
    tick();
    check("ovf_presented", {30'd0, out}, 32'd2);
    in = 4'b0100;
    tick();
    in = 4'b0000;
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    check("ovf_pend", {28'd0, pending}, 32'h4);
    tick();
    check("ovf_oneshot", {31'd0, overflow}, 32'd0);
    ready = 1'b1;
    in    = 4'b0100;
    tick();
    in = 4'b0000;
    check("setwin_noovf", {31'd0, overflow}, 32'd0);
    check("setwin_pend", {28'd0, pending}, 32'h4);
    check("setwin_idle", {31'd0, valid}, 32'd0);
    tick();
    check("setwin_reissue", {31'd0, valid}, 32'd1);
    tick();
    check("setwin_done", {28'd0, pending}, 32'd0);
    check("setwin_drain", exp_q.size(), 32'd0);

    // Reset while a code is presented discards everything.
    do_reset();
    ready = 1'b0;
    in    = 4'b1110;
    tick();
    in = 4'b0000;
    tick();
    check("mid_valid", {31'd0, valid}, 32'd1);
    check("mid_pend", {28'd0, pending}, 32'hE);
    reset = 1'b1;
    in    = 4'b1111;
    ready = 1'b1;
    tick();
    reset = 1'b0;
    in    = 4'b0000;
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_pend", {28'd0, pending}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    in = 4'b1001;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    tick();
    in = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    check("mid_idle", {31'd0, valid}, 32'd0);
    check("mid_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
